conv_layer_scheduler: RTL and testbench

Sequencer for one convolution layer built on the parallel conv engine array. On `start` it walks every kernel of the layer in turn. For each kernel it issues kernel-row reads to the kernel memory and drives the engine's `kernel_load`. It then streams every image column from the image buffer with `valid_in`. It produces result-buffer write strobes and addresses aligned with the engine's output latency. It owns no data path: memory read data goes directly to the engine, and engine outputs go directly to the result buffer.

---
 rtl/conv_sched_pkg.sv | 21 ++
 rtl/conv_sched_delay.sv | 43 ++++
 rtl/conv_layer_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_conv_layer_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and sizing helpers for the convolution layer scheduler.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_KERNEL = 3'd1,
        ST_STREAM      = 3'd2,
        ST_DRAIN       = 3'd3,
        ST_DONE        = 3'd4
    } sched_state_t;

    function automatic int out_cols(input int image_size, input int kernel_size, input int stride);
        return (image_size - kernel_size) / stride + 1;
    endfunction

    // Width of a field holding 0..n-1, never narrower than one bit.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_sched_delay.sv
// Valid+index shift register that aligns result-buffer writes with the engine latency.
module conv_sched_delay #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    if (DEPTH < 1) begin : g_depth_chk
        $error("conv_sched_delay: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] vld_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    // Shift stage chain; a flush empties every stage so nothing already in flight is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
            vld_q[0] <= valid_i;
            idx_q[0] <= idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign idx_o   = idx_q[DEPTH-1];

endmodule

// File: rtl/conv_layer_scheduler.sv
// Control-only sequencer for one convolution layer: kernel loads, image streaming
// and latency-aligned result-buffer writes for every kernel in turn.
module conv_layer_scheduler
    import conv_sched_pkg::*;
#(
    parameter int  KERNEL_SIZE = 4,
    parameter int  IMAGE_SIZE  = 10,
    parameter int  STRIDE      = 1,
    parameter int  NUM_KERNELS = 4,
    parameter int  ENG_LATENCY = 1,
    localparam int OUT_COLS    = out_cols(IMAGE_SIZE, KERNEL_SIZE, STRIDE),
    localparam int KA_W        = safe_clog2(NUM_KERNELS * KERNEL_SIZE),
    localparam int IA_W        = safe_clog2(IMAGE_SIZE),
    localparam int RA_W        = safe_clog2(NUM_KERNELS * OUT_COLS),
    localparam int KI_W        = safe_clog2(NUM_KERNELS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            ker_rd_en,
    output logic [KA_W-1:0] ker_rd_addr,
    output logic            img_rd_en,
    output logic [IA_W-1:0] img_rd_addr,
    output logic            eng_kernel_load,
    output logic            eng_valid_in,
    output logic            res_wr_en,
    output logic [RA_W-1:0] res_wr_addr,
    output logic [KI_W-1:0] kernel_idx
);

    localparam int ROW_W = safe_clog2(KERNEL_SIZE);
    localparam int DRN_W = safe_clog2(ENG_LATENCY + 1);
    localparam int C_W   = safe_clog2(OUT_COLS);

    if ((IMAGE_SIZE - KERNEL_SIZE) % STRIDE != 0) begin : g_stride_chk
        $error("conv_layer_scheduler: (IMAGE_SIZE-KERNEL_SIZE) must be a multiple of STRIDE");
    end

    sched_state_t     state_q, state_d;
    logic [KI_W-1:0]  k_q, k_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [IA_W-1:0]  col_q, col_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic [C_W-1:0]   c_q, c_d;
    logic             abort_hit_s;
    logic             win_s;
    logic [RA_W-1:0]  push_idx_s;
    int               eng_col_s;

    logic             busy_q, done_q, ker_rd_en_q, img_rd_en_q;
    logic             eng_kernel_load_q, eng_valid_in_q;
    logic [KA_W-1:0]  ker_rd_addr_q;
    logic [IA_W-1:0]  img_rd_addr_q, eng_col_q;
    logic [KI_W-1:0]  kernel_idx_q;

    // Next-state and counter sequencing; abort overrides every transition except from IDLE.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        col_d       = col_q;
        drn_d       = drn_q;
        abort_hit_s = abort && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_KERNEL;
                    k_d     = '0;
                    row_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_KERNEL: begin
                if (row_q == ROW_W'(KERNEL_SIZE - 1)) begin
                    state_d = ST_STREAM;
                    col_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            ST_STREAM: begin
                if (col_q == IA_W'(IMAGE_SIZE - 1)) begin
                    state_d = ST_DRAIN;
                    drn_d   = '0;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drn_q != DRN_W'(ENG_LATENCY)) begin
                    drn_d = drn_q + 1'b1;
                end else if (k_q == KI_W'(NUM_KERNELS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD_KERNEL;
                    k_d     = k_q + 1'b1;
                    row_d   = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_hit_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Window completion seen at the engine input, and the output-column counter it advances.
    always_comb begin
        eng_col_s = int'(eng_col_q);
        if (eng_valid_in_q && (eng_col_s >= KERNEL_SIZE - 1)
            && (((eng_col_s - (KERNEL_SIZE - 1)) % STRIDE) == 0)) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (state_q == ST_LOAD_KERNEL) begin
            c_d = '0;
        end else if (win_s && (c_q != C_W'(OUT_COLS - 1))) begin
            c_d = c_q + 1'b1;
        end else begin
            c_d = c_q;
        end
        push_idx_s = RA_W'(int'(k_q) * OUT_COLS + int'(c_q));
    end

    // State, counters and registered outputs; strobes are loaded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            k_q               <= '0;
            row_q             <= '0;
            col_q             <= '0;
            drn_q             <= '0;
            c_q               <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            ker_rd_en_q       <= 1'b0;
            ker_rd_addr_q     <= '0;
            img_rd_en_q       <= 1'b0;
            img_rd_addr_q     <= '0;
            eng_kernel_load_q <= 1'b0;
            eng_valid_in_q    <= 1'b0;
            eng_col_q         <= '0;
            kernel_idx_q      <= '0;
        end else begin
            state_q           <= state_d;
            k_q               <= k_d;
            row_q             <= row_d;
            col_q             <= col_d;
            drn_q             <= drn_d;
            c_q               <= c_d;
            busy_q            <= (state_d != ST_IDLE);
            done_q            <= (state_d == ST_DONE);
            ker_rd_en_q       <= (state_d == ST_LOAD_KERNEL);
            ker_rd_addr_q     <= KA_W'(int'(k_d) * KERNEL_SIZE + int'(row_d));
            img_rd_en_q       <= (state_d == ST_STREAM);
            img_rd_addr_q     <= col_d;
            eng_kernel_load_q <= ker_rd_en_q && !abort_hit_s;
            eng_valid_in_q    <= img_rd_en_q && !abort_hit_s;
            eng_col_q         <= img_rd_addr_q;
            kernel_idx_q      <= (state_d == ST_IDLE) ? '0 : k_d;
        end
    end

    conv_sched_delay #(
        .DEPTH (ENG_LATENCY),
        .IDX_W (RA_W)
    ) u_res_dly (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort_hit_s),
        .valid_i (win_s),
        .idx_i   (push_idx_s),
        .valid_o (res_wr_en),
        .idx_o   (res_wr_addr)
    );

    assign busy            = busy_q;
    assign done            = done_q;
    assign ker_rd_en       = ker_rd_en_q;
    assign ker_rd_addr     = ker_rd_addr_q;
    assign img_rd_en       = img_rd_en_q;
    assign img_rd_addr     = img_rd_addr_q;
    assign eng_kernel_load = eng_kernel_load_q;
    assign eng_valid_in    = eng_valid_in_q;
    assign kernel_idx      = kernel_idx_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench: three scheduler configurations (baseline, stride 2, latency 3) driven in lockstep
// and compared every cycle against a timeline model derived from the layer schedule.
module tb_conv_layer_scheduler;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] o_busy [3], o_done [3], o_ke [3], o_ka [3], o_ie [3], o_ia [3];
    logic [31:0] o_kl [3], o_vi [3], o_we [3], o_wa [3], o_ki [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S  = (g == 1) ? 2 : 1;
        localparam int L  = (g == 2) ? 3 : 1;
        localparam int OC = (10 - 4) / S + 1;
        localparam int RW = $clog2(2 * OC);
        logic          busy, done, ke, ie, kl, vi, we;
        logic [2:0]    ka;
        logic [3:0]    ia;
        logic [RW-1:0] wa;
        logic [0:0]    ki;

        conv_layer_scheduler #(
            .KERNEL_SIZE (4),
            .IMAGE_SIZE  (10),
            .STRIDE      (S),
            .NUM_KERNELS (2),
            .ENG_LATENCY (L)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start),
            .abort           (abort),
            .busy            (busy),
            .done            (done),
            .ker_rd_en       (ke),
            .ker_rd_addr     (ka),
            .img_rd_en       (ie),
            .img_rd_addr     (ia),
            .eng_kernel_load (kl),
            .eng_valid_in    (vi),
            .res_wr_en       (we),
            .res_wr_addr     (wa),
            .kernel_idx      (ki)
        );

        assign o_busy[g] = 32'(busy);
        assign o_done[g] = 32'(done);
        assign o_ke[g]   = 32'(ke);
        assign o_ka[g]   = 32'(ka);
        assign o_ie[g]   = 32'(ie);
        assign o_ia[g]   = 32'(ia);
        assign o_kl[g]   = 32'(kl);
        assign o_vi[g]   = 32'(vi);
        assign o_we[g]   = 32'(we);
        assign o_wa[g]   = 32'(wa);
        assign o_ki[g]   = 32'(ki);
    end

    // Reference model: per configuration, whether a run is active and the cycle index t
    // within it (t=1 is the cycle after start was sampled).
    bit run_m [3];
    int t_m   [3];
    int wr_cnt[3];
    int done_cnt0;

    function automatic int cfg_s(input int d); return (d == 1) ? 2 : 1; endfunction
    function automatic int cfg_l(input int d); return (d == 2) ? 3 : 1; endfunction
    function automatic int cfg_p(input int d); return 4 + 10 + cfg_l(d) + 1; endfunction
    function automatic int cfg_oc(input int d); return (10 - 4) / cfg_s(d) + 1; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                run_m[d] = 1'b0;
            end else if (!run_m[d]) begin
                if (start) begin
                    run_m[d] = 1'b1;
                    t_m[d]   = 1;
                end
            end else if (abort || (t_m[d] == 2 * cfg_p(d) + 1)) begin
                run_m[d] = 1'b0;
            end else begin
                t_m[d]++;
            end
        end
    endtask

    task automatic check_dut(input int d, input string ph);
        logic [31:0] e_busy, e_done, e_ke, e_ka, e_ie, e_ia, e_kl, e_vi, e_we, e_wa, e_ki;
        int p, k, q, j, s;
        string pre;
        {e_busy, e_done, e_ke, e_ka, e_ie, e_ia} = '0;
        {e_kl, e_vi, e_we, e_wa, e_ki} = '0;
        p = cfg_p(d);
        s = cfg_s(d);
        if (run_m[d]) begin
            e_busy = 32'd1;
            if (t_m[d] == 2 * p + 1) begin
                e_done = 32'd1;
                e_ki   = 32'd1;
            end else begin
                k    = (t_m[d] - 1) / p;
                q    = (t_m[d] - 1) % p;
                e_ki = k;
                e_ke = 32'(q < 4);
                e_ka = k * 4 + q;
                e_ie = 32'(q >= 4 && q < 14);
                e_ia = q - 4;
                e_kl = 32'(q >= 1 && q <= 4);
                e_vi = 32'(q >= 5 && q <= 14);
                j    = q - 5 - cfg_l(d);
                if (j >= 3 && j <= 9 && ((j - 3) % s) == 0) begin
                    e_we = 32'd1;
                    e_wa = k * cfg_oc(d) + (j - 3) / s;
                end
            end
        end
        pre = $sformatf("%s d%0d t%0d", ph, d, t_m[d]);
        chk({pre, " busy"}, o_busy[d], e_busy);
        chk({pre, " done"}, o_done[d], e_done);
        chk({pre, " ker_rd_en"}, o_ke[d], e_ke);
        chk({pre, " img_rd_en"}, o_ie[d], e_ie);
        chk({pre, " kernel_load"}, o_kl[d], e_kl);
        chk({pre, " valid_in"}, o_vi[d], e_vi);
        chk({pre, " res_wr_en"}, o_we[d], e_we);
        chk({pre, " kernel_idx"}, o_ki[d], e_ki);
        if (e_ke == 32'd1) chk({pre, " ker_rd_addr"}, o_ka[d], e_ka);
        if (e_ie == 32'd1) chk({pre, " img_rd_addr"}, o_ia[d], e_ia);
        if (e_we == 32'd1) chk({pre, " res_wr_addr"}, o_wa[d], e_wa);
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_dut(d, ph);
            if (o_we[d] === 32'd1) wr_cnt[d]++;
        end
        if (o_done[0] === 32'd1) done_cnt0++;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            run_m[d]  = 1'b0;
            t_m[d]    = 0;
            wr_cnt[d] = 0;
        end
        done_cnt0 = 0;

        rst_n = 1'b0;
        repeat (3) tick("reset");
        rst_n = 1'b1;
        tick("post_reset");

        // Single complete run; write counts per configuration.
        start = 1'b1;
        tick("single");
        start = 1'b0;
        repeat (40) tick("single");
        chk("writes d0", 32'(wr_cnt[0]), 32'd14);
        chk("writes d1", 32'(wr_cnt[1]), 32'd8);
        chk("writes d2", 32'(wr_cnt[2]), 32'd14);

        // Abort while the baseline is at kernel 1, streaming column 5, then relaunch.
        start = 1'b1;
        tick("abort_run");
        start = 1'b0;
        repeat (25) tick("abort_run");
        abort = 1'b1;
        tick("abort");
        abort = 1'b0;
        repeat (3) tick("after_abort");
        start = 1'b1;
        tick("restart");
        start = 1'b0;
        repeat (40) tick("restart");

        // Asynchronous reset during the drain of kernel 0.
        start = 1'b1;
        tick("rst_run");
        start = 1'b0;
        repeat (14) tick("rst_run");
        #2 rst_n = 1'b0;
        for (int d = 0; d < 3; d++) run_m[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check_dut(d, "async_rst");
        repeat (2) tick("in_reset");
        rst_n = 1'b1;
        repeat (8) tick("rst_release");

        // Start held across a whole run and beyond: one done, then a fresh launch.
        done_cnt0 = 0;
        start = 1'b1;
        repeat (40) tick("held");
        start = 1'b0;
        chk("held done count", 32'(done_cnt0), 32'd1);
        repeat (45) tick("held_tail");

        // Randomised start/abort traffic.
        repeat (1500) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 47) == 0);
            tick("random");
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (40) tick("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
